paddle_track_ctrl: RTL and testbench

PADDLE_TRACK_CTRL -- requirements
Module: paddle_track_ctrl

---
 rtl/paddle_pkg.sv | 26 ++
 rtl/vsync_edge_det.sv | 35 +++
 rtl/paddle_track_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_paddle_track_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// -----------------------------------------------------------------------------
// paddle_pkg
// Shared definitions for the paddle tracking controller: the track-state
// encoding seen on track_state and the default parameter values used by
// paddle_track_ctrl.
// -----------------------------------------------------------------------------
package paddle_pkg;

    // Track-state codes; the numeric values are visible on the track_state port.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLD    = 2'd3
    } track_state_t;

    // Default coordinate width in bits.
    localparam int DEF_W           = 13;
    // Default number of consecutive good frames needed to lock.
    localparam int DEF_ACQ_FRAMES  = 3;
    // Default number of consecutive bad frames that drop the lock.
    localparam int DEF_LOST_FRAMES = 8;
    // Default largest accepted per-axis movement between frames, in pixels.
    localparam int DEF_MAX_JUMP    = 64;

endpackage : paddle_pkg

// File: rtl/vsync_edge_det.sv
// -----------------------------------------------------------------------------
// vsync_edge_det
// Registers vsync and flags the frame sample point: the cycle in which the
// registered copy is still high while the live vsync has already dropped.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-low reset (clears the vsync register)
//   vsync     in   frame sync from the video pipe
//   sample_pt out  high for the one cycle at each vsync falling edge
// -----------------------------------------------------------------------------
module vsync_edge_det
    import paddle_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic sample_pt
);

    logic vsync_d_r;

    // Delayed copy of vsync; cleared on reset so that a falling edge in
    // progress at reset time is not treated as a sample point afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vsync_d_r <= 1'b0;
        end else begin
            vsync_d_r <= vsync;
        end
    end

    assign sample_pt = vsync_d_r & ~vsync;

endmodule : vsync_edge_det

// File: rtl/paddle_track_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_track_ctrl
// Filters the per-frame paddle centre reported by the tracker into a stable
// position for the game logic. A lock is acquired after ACQ_FRAMES
// consecutive plausible detections, the locked position is smoothed by
// averaging with each new sample, and the lock survives up to LOST_FRAMES-1
// consecutive bad frames (HOLD) before falling back to SEARCH.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   vsync        in   frame sync; the frame is sampled at its falling edge
//   det_valid    in   tracker found a paddle this frame
//   center_x/y   in   tracker paddle centre [W-1:0]
//   paddle_x/y   out  filtered paddle position [W-1:0]
//   paddle_valid out  position usable (TRACK or HOLD)
//   track_state  out  SEARCH=0, ACQUIRE=1, TRACK=2, HOLD=3
//   frame_tick   out  one-cycle pulse in the cycle the outputs update
// -----------------------------------------------------------------------------
module paddle_track_ctrl
    import paddle_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int ACQ_FRAMES  = DEF_ACQ_FRAMES,
    parameter int LOST_FRAMES = DEF_LOST_FRAMES,
    parameter int MAX_JUMP    = DEF_MAX_JUMP
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         vsync,
    input  logic         det_valid,
    input  logic [W-1:0] center_x,
    input  logic [W-1:0] center_y,
    output logic [W-1:0] paddle_x,
    output logic [W-1:0] paddle_y,
    output logic         paddle_valid,
    output logic [1:0]   track_state,
    output logic         frame_tick
);

    // One counter width serves both acq_cnt and lost_cnt.
    localparam int CNT_MAX = (ACQ_FRAMES > LOST_FRAMES) ? ACQ_FRAMES : LOST_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    // Counter value at which one more increment reaches the threshold.
    localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(ACQ_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_FRAMES - 1);

    localparam logic signed [W:0] MAX_JUMP_S = (W+1)'(MAX_JUMP);

    // Saturating increment: the frame counters never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_SAT) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    // Absolute value of a W+1-bit signed difference of two W-bit unsigned
    // values; the magnitude always fits because |a-b| <= 2^W-1.
    function automatic logic signed [W:0] abs_diff(input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        logic signed [W:0] d;
        logic signed [W:0] res;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[W]) begin
            res = -d;
        end else begin
            res = d;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    track_state_t     state_r,      state_n_s;
    logic [W-1:0]     paddle_x_r,   paddle_x_n_s;
    logic [W-1:0]     paddle_y_r,   paddle_y_n_s;
    logic [W-1:0]     ref_x_r,      ref_x_n_s;
    logic [W-1:0]     ref_y_r,      ref_y_n_s;
    logic [CNT_W-1:0] acq_cnt_r,    acq_cnt_n_s;
    logic [CNT_W-1:0] lost_cnt_r,   lost_cnt_n_s;
    logic             paddle_valid_r, paddle_valid_n_s;
    logic             frame_tick_r;

    logic             sample_pt_s;
    logic [W-1:0]     cmp_x_s;
    logic [W-1:0]     cmp_y_s;
    logic             good_s;
    logic [W:0]       sum_x_s;
    logic [W:0]       sum_y_s;
    logic [W-1:0]     avg_x_s;
    logic [W-1:0]     avg_y_s;

    vsync_edge_det u_vsync_edge_det (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .sample_pt (sample_pt_s)
    );

    // Jump check against the acquisition reference (ACQUIRE) or the locked
    // position (TRACK/HOLD), plus the smoothing average for the locked path.
    always_comb begin
        cmp_x_s = ref_x_r;
        cmp_y_s = ref_y_r;
        if ((state_r == ST_TRACK) || (state_r == ST_HOLD)) begin
            cmp_x_s = paddle_x_r;
            cmp_y_s = paddle_y_r;
        end else begin
            cmp_x_s = ref_x_r;
            cmp_y_s = ref_y_r;
        end

        good_s = det_valid
               && (abs_diff(center_x, cmp_x_s) <= MAX_JUMP_S)
               && (abs_diff(center_y, cmp_y_s) <= MAX_JUMP_S);

        // W+1-bit sums so the carry is kept; the shift truncates.
        sum_x_s = {1'b0, paddle_x_r} + {1'b0, center_x};
        sum_y_s = {1'b0, paddle_y_r} + {1'b0, center_y};
        avg_x_s = sum_x_s[W:1];
        avg_y_s = sum_y_s[W:1];
    end

    // Next-state logic; nothing moves except at a sample point.
    always_comb begin
        state_n_s    = state_r;
        paddle_x_n_s = paddle_x_r;
        paddle_y_n_s = paddle_y_r;
        ref_x_n_s    = ref_x_r;
        ref_y_n_s    = ref_y_r;
        acq_cnt_n_s  = acq_cnt_r;
        lost_cnt_n_s = lost_cnt_r;

        if (sample_pt_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (det_valid) begin
                        state_n_s   = ST_ACQUIRE;
                        ref_x_n_s   = center_x;
                        ref_y_n_s   = center_y;
                        acq_cnt_n_s = CNT_ONE;
                    end else begin
                        state_n_s   = ST_SEARCH;
                    end
                end

                ST_ACQUIRE: begin
                    if (good_s) begin
                        acq_cnt_n_s = sat_inc(acq_cnt_r);
                        ref_x_n_s   = center_x;
                        ref_y_n_s   = center_y;
                        if (acq_cnt_r >= ACQ_LAST) begin
                            state_n_s    = ST_TRACK;
                            paddle_x_n_s = center_x;
                            paddle_y_n_s = center_y;
                            lost_cnt_n_s = CNT_ZERO;
                        end else begin
                            state_n_s    = ST_ACQUIRE;
                        end
                    end else if (det_valid) begin
                        // Implausible jump: restart acquisition from here.
                        ref_x_n_s   = center_x;
                        ref_y_n_s   = center_y;
                        acq_cnt_n_s = CNT_ONE;
                    end else begin
                        state_n_s   = ST_SEARCH;
                        acq_cnt_n_s = CNT_ZERO;
                    end
                end

                ST_TRACK: begin
                    if (good_s) begin
                        paddle_x_n_s = avg_x_s;
                        paddle_y_n_s = avg_y_s;
                    end else begin
                        state_n_s    = ST_HOLD;
                        lost_cnt_n_s = CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    if (good_s) begin
                        state_n_s    = ST_TRACK;
                        paddle_x_n_s = avg_x_s;
                        paddle_y_n_s = avg_y_s;
                        lost_cnt_n_s = CNT_ZERO;
                    end else if (lost_cnt_r >= LOST_LAST) begin
                        // Lock dropped; the last position stays on the
                        // outputs but is flagged invalid.
                        state_n_s    = ST_SEARCH;
                        lost_cnt_n_s = CNT_ZERO;
                        acq_cnt_n_s  = CNT_ZERO;
                    end else begin
                        lost_cnt_n_s = sat_inc(lost_cnt_r);
                    end
                end

                default: begin
                    state_n_s = ST_SEARCH;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end

        paddle_valid_n_s = (state_n_s == ST_TRACK) || (state_n_s == ST_HOLD);
    end

    // State, position, counters and the frame tick; reset wins over a
    // coincident sample point.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_SEARCH;
            paddle_x_r     <= '0;
            paddle_y_r     <= '0;
            ref_x_r        <= '0;
            ref_y_r        <= '0;
            acq_cnt_r      <= CNT_ZERO;
            lost_cnt_r     <= CNT_ZERO;
            paddle_valid_r <= 1'b0;
            frame_tick_r   <= 1'b0;
        end else begin
            state_r        <= state_n_s;
            paddle_x_r     <= paddle_x_n_s;
            paddle_y_r     <= paddle_y_n_s;
            ref_x_r        <= ref_x_n_s;
            ref_y_r        <= ref_y_n_s;
            acq_cnt_r      <= acq_cnt_n_s;
            lost_cnt_r     <= lost_cnt_n_s;
            paddle_valid_r <= paddle_valid_n_s;
            frame_tick_r   <= sample_pt_s;
        end
    end

    assign paddle_x     = paddle_x_r;
    assign paddle_y     = paddle_y_r;
    assign paddle_valid = paddle_valid_r;
    assign track_state  = state_r;
    assign frame_tick   = frame_tick_r;

endmodule : paddle_track_ctrl

// File: tb/tb_paddle_track_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_track_ctrl
// Table-driven bench: each row is one frame (stimulus + expected outputs).
// Expectations are queued when a frame is driven and checked when the DUT
// raises frame_tick. Hand-written sequences cover reset during a sample
// point and input glitches between sample points.
// -----------------------------------------------------------------------------
module tb_paddle_track_ctrl;

    localparam int W = 13;

    logic         clk;
    logic         reset;
    logic         vsync;
    logic         det_valid;
    logic [W-1:0] center_x;
    logic [W-1:0] center_y;
    logic [W-1:0] paddle_x;
    logic [W-1:0] paddle_y;
    logic         paddle_valid;
    logic [1:0]   track_state;
    logic         frame_tick;

    typedef struct {
        logic         dv;
        logic [W-1:0] cx;
        logic [W-1:0] cy;
        logic [1:0]   st;
        logic [W-1:0] px;
        logic [W-1:0] py;
        logic         pv;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];
    vec_t exp_q[$];

    int n_cmp    = 0;
    int n_err    = 0;
    int tick_cnt = 0;

    paddle_track_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .det_valid    (det_valid),
        .center_x     (center_x),
        .center_y     (center_y),
        .paddle_x     (paddle_x),
        .paddle_y     (paddle_y),
        .paddle_valid (paddle_valid),
        .track_state  (track_state),
        .frame_tick   (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic dv, input int cx, input int cy,
                                input int st, input int px, input int py, input logic pv);
        vec_t v;
        v.dv = dv;
        v.cx = W'(cx);
        v.cy = W'(cy);
        v.st = 2'(st);
        v.px = W'(px);
        v.py = W'(py);
        v.pv = pv;
        return v;
    endfunction

    // Scoreboard: every frame_tick consumes one queued expectation.
    always @(negedge clk) begin
        if (frame_tick === 1'b1) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame_tick", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                check("track_state",  32'(track_state),  32'(e.st));
                check("paddle_x",     32'(paddle_x),     32'(e.px));
                check("paddle_y",     32'(paddle_y),     32'(e.py));
                check("paddle_valid", 32'(paddle_valid), 32'(e.pv));
            end
        end
    end

    task automatic scramble();
        det_valid = 1'($urandom_range(0, 1));
        center_x  = W'($urandom);
        center_y  = W'($urandom);
    endtask

    // One frame: vsync high 3 cycles with junk inputs, then the real sample
    // presented as vsync falls; wait (bounded) for the matching frame_tick.
    task automatic run_frame(input vec_t v);
        int t0;
        bit seen;
        exp_q.push_back(v);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vsync = 1'b1;
            scramble();
        end
        @(posedge clk); #1;
        vsync     = 1'b0;
        det_valid = v.dv;
        center_x  = v.cx;
        center_y  = v.cy;
        t0 = tick_cnt;
        @(posedge clk); #1;
        scramble();
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk); #1;
            seen = (tick_cnt != t0);
        end
        check("frame_tick_seen", 32'(seen), 32'd1);
        if (!seen && exp_q.size() != 0) begin
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        scramble();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;

        // Frame table from reset: acquire, smooth, jump reject at the 64/65
        // boundary, loss, acquisition restart, loss again, partial acquire.
        vecs_a.push_back(mk(1'b1, 320, 240, 1,   0,   0, 1'b0));
        vecs_a.push_back(mk(1'b1, 320, 240, 1,   0,   0, 1'b0));
        vecs_a.push_back(mk(1'b1, 320, 240, 2, 320, 240, 1'b1));
        vecs_a.push_back(mk(1'b1, 340, 250, 2, 330, 245, 1'b1));
        vecs_a.push_back(mk(1'b1, 341, 250, 2, 335, 247, 1'b1));
        vecs_a.push_back(mk(1'b1, 400, 247, 3, 335, 247, 1'b1));
        vecs_a.push_back(mk(1'b1, 399, 247, 2, 367, 247, 1'b1));
        vecs_a.push_back(mk(1'b0,   0,   0, 3, 367, 247, 1'b1));
        vecs_a.push_back(mk(1'b1, 367, 183, 2, 367, 215, 1'b1));
        for (int i = 0; i < 7; i++) vecs_a.push_back(mk(1'b0, 0, 0, 3, 367, 215, 1'b1));
        vecs_a.push_back(mk(1'b0,   0,   0, 0, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b0,   0,   0, 0, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b1, 100, 100, 1, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b1, 300, 100, 1, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b1, 300, 100, 1, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b0,   0,   0, 0, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b1, 100, 100, 1, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b1, 100, 100, 1, 367, 215, 1'b0));
        vecs_a.push_back(mk(1'b1, 100, 100, 2, 100, 100, 1'b1));
        vecs_a.push_back(mk(1'b1, 200, 100, 3, 100, 100, 1'b1));
        vecs_a.push_back(mk(1'b1, 110, 100, 2, 105, 100, 1'b1));
        for (int i = 0; i < 7; i++) vecs_a.push_back(mk(1'b0, 0, 0, 3, 105, 100, 1'b1));
        vecs_a.push_back(mk(1'b0,   0,   0, 0, 105, 100, 1'b0));
        vecs_a.push_back(mk(1'b1,  50,  50, 1, 105, 100, 1'b0));
        vecs_a.push_back(mk(1'b1,  50,  50, 1, 105, 100, 1'b0));

        // After the mid-acquire reset, a full fresh acquisition is needed.
        vecs_b.push_back(mk(1'b1, 320, 240, 1,   0,   0, 1'b0));
        vecs_b.push_back(mk(1'b1, 320, 240, 1,   0,   0, 1'b0));
        vecs_b.push_back(mk(1'b1, 320, 240, 2, 320, 240, 1'b1));

        reset     = 1'b0;
        vsync     = 1'b0;
        det_valid = 1'b0;
        center_x  = '0;
        center_y  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_track_state",  32'(track_state),  32'd0);
        check("rst_paddle_x",     32'(paddle_x),     32'd0);
        check("rst_paddle_y",     32'(paddle_y),     32'd0);
        check("rst_paddle_valid", 32'(paddle_valid), 32'd0);
        check("rst_frame_tick",   32'(frame_tick),   32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (vecs_a[i]) run_frame(vecs_a[i]);

        // Reset pulse on the sample cycle while in ACQUIRE with acq_cnt=2.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vsync = 1'b1;
            scramble();
        end
        @(posedge clk); #1;
        vsync     = 1'b0;
        det_valid = 1'b1;
        center_x  = W'(50);
        center_y  = W'(50);
        reset     = 1'b0;
        t0 = tick_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_mid_no_tick",      32'(tick_cnt),     32'(t0));
        check("rst_mid_track_state",  32'(track_state),  32'd0);
        check("rst_mid_paddle_x",     32'(paddle_x),     32'd0);
        check("rst_mid_paddle_y",     32'(paddle_y),     32'd0);
        check("rst_mid_paddle_valid", 32'(paddle_valid), 32'd0);

        foreach (vecs_b[i]) run_frame(vecs_b[i]);

        // Glitches away from the sample point: vsync low, then vsync high.
        t0 = tick_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vsync     = 1'b0;
            det_valid = 1'b1;
            center_x  = W'(1000 + 37 * i);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vsync     = 1'b1;
            det_valid = 1'b1;
            center_x  = W'(2000 + 53 * i);
        end
        @(negedge clk); #1;
        check("glitch_no_tick",      32'(tick_cnt),     32'(t0));
        check("glitch_track_state",  32'(track_state),  32'd2);
        check("glitch_paddle_x",     32'(paddle_x),     32'd320);
        check("glitch_paddle_y",     32'(paddle_y),     32'd240);
        check("glitch_paddle_valid", 32'(paddle_valid), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_paddle_track_ctrl
